// File: rtl/wb_arbiter.sv
// wb_arbiter: merges in-order pipeline writebacks and buffered long-latency results onto one
// register-file write port, tracking pending destinations in a busy scoreboard.
module wb_arbiter #(
  parameter int DATA_W    = 32,
  parameter int REG_NUM   = 32,
  parameter int BUF_DEPTH = 2,
  localparam int AW = $clog2(REG_NUM),
  localparam int PW = $clog2(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [AW-1:0]     pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [AW-1:0]     lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_waddr,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              we,
  output logic [AW-1:0]     waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              err
);
  localparam logic [PW:0] FULL = (PW+1)'(BUF_DEPTH);
  logic [AW-1:0]      ba_q [BUF_DEPTH];
  logic [DATA_W-1:0]  bd_q [BUF_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]        count_q, count_d;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               we_q, we_d, err_q, err_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               acc, acc_nz, pipe_v, pop, bypass, push, clr, set, issue_err, lu_err;
  logic [AW-1:0]      clr_a;
  assign lu_ready  = rst && (count_q < FULL);
  assign acc       = lu_valid && lu_ready;
  assign acc_nz    = acc && (lu_waddr != '0);
  assign pipe_v    = pipe_we && (pipe_waddr != '0);
  assign pop       = !pipe_v && (count_q != '0);
  assign bypass    = !pipe_v && (count_q == '0) && acc_nz;
  assign push      = acc_nz && !bypass;
  assign clr       = pop || bypass;
  assign clr_a     = pop ? ba_q[rd_ptr_q] : lu_waddr;
  assign set       = issue_valid && (issue_waddr != '0);
  // A re-issue is legal only when the previous result retires in the same cycle.
  assign issue_err = set && busy_q[issue_waddr] && !(clr && clr_a == issue_waddr);
  assign lu_err    = acc_nz && !busy_q[lu_waddr];
  assign hazard1   = busy_q[raddr1];
  assign hazard2   = busy_q[raddr2];
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign err       = err_q;
  always_comb begin
    we_d     = pipe_v || clr;
    waddr_d  = pipe_v ? pipe_waddr : pop ? ba_q[rd_ptr_q] : bypass ? lu_waddr : waddr_q;
    wdata_d  = pipe_v ? pipe_wdata : pop ? bd_q[rd_ptr_q] : bypass ? lu_wdata : wdata_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    err_d    = err_q || issue_err || lu_err;
    busy_d   = busy_q;
    if (clr) busy_d[clr_a] = 1'b0;
    if (set) busy_d[issue_waddr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      ba_q[wr_ptr_q] <= lu_waddr;
      bd_q[wr_ptr_q] <= lu_wdata;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table plus randomized traffic checked against a queue-based model.
module tb_wb_arbiter;
  localparam int D = 2;
  logic clk = 0, rst = 0, pipe_we = 0, lu_valid = 0, issue_valid = 0;
  logic [4:0] pipe_waddr = 0, lu_waddr = 0, issue_waddr = 0, raddr1 = 0, raddr2 = 0, waddr;
  logic [31:0] pipe_wdata = 0, lu_wdata = 0, wdata;
  logic lu_ready, hazard1, hazard2, we, err;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  wb_arbiter #(.DATA_W(32), .REG_NUM(32), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr), .raddr1(raddr1), .raddr2(raddr2),
    .hazard1(hazard1), .hazard2(hazard2), .we(we), .waddr(waddr), .wdata(wdata), .err(err));
  typedef struct {
    logic rst, pwe; logic [4:0] pa; logic [31:0] pd;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic iv; logic [4:0] ia, r1, r2;
    logic ewe; logic [4:0] ewa; logic [31:0] ewd; logic eh, erdy, eerr;
  } vec_t;
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  vec_t tbl[$];
  ent_t q[$];
  bit [31:0] mbusy;
  bit merr, mwe;
  logic [4:0] mwa;
  logic [31:0] mwd;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic add(input logic rs, pwe, input logic [4:0] pa, input logic [31:0] pd,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic iv, input logic [4:0] ia, r1,
                     input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                     input logic eh, erdy, eerr);
    vec_t v;
    v = '{rs, pwe, pa, pd, lv, la, ld, iv, ia, r1, r1, ewe, ewa, ewd, eh, erdy, eerr};
    tbl.push_back(v);
  endtask
  task automatic model(input vec_t v);
    bit [31:0] ob;
    bit acc, clrv;
    logic [4:0] ca;
    ent_t e;
    ob = mbusy;
    clrv = 0;
    ca = 0;
    if (!v.rst) begin
      q.delete();
      mbusy = 0;
      merr = 0;
      mwe = 0;
      mwa = 0;
      mwd = 0;
      return;
    end
    acc = v.lv && (q.size() < D);
    if (v.pwe && v.pa != 0) begin
      mwe = 1; mwa = v.pa; mwd = v.pd;
      if (acc && v.la != 0) q.push_back('{v.la, v.ld});
    end else if (q.size() > 0) begin
      e = q.pop_front();
      mwe = 1; mwa = e.a; mwd = e.d; clrv = 1; ca = e.a;
      if (acc && v.la != 0) q.push_back('{v.la, v.ld});
    end else if (acc && v.la != 0) begin
      mwe = 1; mwa = v.la; mwd = v.ld; clrv = 1; ca = v.la;
    end else mwe = 0;
    if (clrv) mbusy[ca] = 0;
    if (acc && v.la != 0 && !ob[v.la]) merr = 1;
    if (v.iv && v.ia != 0) begin
      if (ob[v.ia] && !(clrv && ca == v.ia)) merr = 1;
      mbusy[v.ia] = 1;
    end
  endtask
  task automatic apply(input vec_t v, input bit tab);
    rst = v.rst; pipe_we = v.pwe; pipe_waddr = v.pa; pipe_wdata = v.pd;
    lu_valid = v.lv; lu_waddr = v.la; lu_wdata = v.ld;
    issue_valid = v.iv; issue_waddr = v.ia; raddr1 = v.r1; raddr2 = v.r2;
    #1;
    chk("lu_ready", lu_ready, v.rst && (q.size() < D));
    chk("hazard1", hazard1, mbusy[v.r1]);
    chk("hazard2", hazard2, mbusy[v.r2]);
    model(v);
    @(posedge clk);
    #1;
    chk("we", we, mwe);
    chk("waddr", waddr, mwa);
    chk("wdata", wdata, mwd);
    chk("err", err, merr);
    if (tab) begin
      chk("tbl_we", we, v.ewe);
      chk("tbl_waddr", waddr, v.ewa);
      chk("tbl_wdata", wdata, v.ewd);
      chk("tbl_hazard1", hazard1, v.eh);
      chk("tbl_lu_ready", lu_ready, v.erdy);
      chk("tbl_err", err, v.eerr);
    end
  endtask
  initial begin
    vec_t v;
    //  rs pwe pa pd     lv la ld      iv ia  r1  we wa wd      h  rdy err
    add(0, 0, 0, 0,      1, 10, 5,     1, 12, 12, 0, 0, 0,      0, 0, 0);
    add(1, 0, 0, 0,      0, 0, 0,      1, 5,  5,  0, 0, 0,      1, 1, 0);
    add(1, 0, 0, 0,      1, 5, 'h1234, 0, 0,  5,  1, 5, 'h1234, 0, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      1, 7,  7,  0, 5, 'h1234, 1, 1, 0);
    add(1, 1, 3, 'hA,    1, 7, 'hB,    0, 0,  7,  1, 3, 'hA,    1, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      0, 0,  7,  1, 7, 'hB,    0, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      1, 8,  8,  0, 7, 'hB,    1, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      1, 9,  8,  0, 7, 'hB,    1, 1, 0);
    add(1, 1, 1, 'h11,   1, 8, 'h80,   0, 0,  8,  1, 1, 'h11,   1, 1, 0);
    add(1, 1, 1, 'h12,   1, 9, 'h90,   0, 0,  9,  1, 1, 'h12,   1, 0, 0);
    add(1, 1, 1, 'h13,   1, 10, 'hAA,  0, 0,  9,  1, 1, 'h13,   1, 0, 0);
    add(1, 1, 1, 'h14,   0, 0, 0,      0, 0,  9,  1, 1, 'h14,   1, 0, 0);
    add(1, 0, 0, 0,      0, 0, 0,      0, 0,  8,  1, 8, 'h80,   0, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      0, 0,  9,  1, 9, 'h90,   0, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      0, 0,  9,  0, 9, 'h90,   0, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      1, 4,  4,  0, 9, 'h90,   1, 1, 0);
    add(1, 1, 2, 'h22,   1, 4, 'h44,   0, 0,  4,  1, 2, 'h22,   1, 1, 0);
    add(1, 1, 0, 'h55,   0, 0, 0,      0, 0,  4,  1, 4, 'h44,   0, 1, 0);
    add(1, 0, 0, 0,      1, 0, 'h66,   0, 0,  4,  0, 4, 'h44,   0, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      1, 6,  6,  0, 4, 'h44,   1, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      1, 6,  6,  0, 4, 'h44,   1, 1, 1);
    add(1, 0, 0, 0,      0, 0, 0,      0, 0,  6,  0, 4, 'h44,   1, 1, 1);
    add(0, 0, 0, 0,      0, 0, 0,      0, 0,  6,  0, 0, 0,      0, 0, 0);
    add(1, 0, 0, 0,      1, 9, 'h77,   0, 0,  9,  1, 9, 'h77,   0, 1, 1);
    add(1, 0, 0, 0,      0, 0, 0,      0, 0,  9,  0, 9, 'h77,   0, 1, 1);
    add(1, 0, 0, 0,      0, 0, 0,      1, 10, 10, 0, 9, 'h77,   1, 1, 1);
    add(1, 0, 0, 0,      0, 0, 0,      1, 11, 10, 0, 9, 'h77,   1, 1, 1);
    add(1, 1, 1, 1,      1, 10, 'hA0,  0, 0,  10, 1, 1, 1,      1, 1, 1);
    add(1, 1, 1, 2,      1, 11, 'hB0,  0, 0,  11, 1, 1, 2,      1, 0, 1);
    add(0, 0, 0, 0,      1, 12, 'hC0,  1, 13, 10, 0, 0, 0,      0, 0, 0);
    add(1, 0, 0, 0,      0, 0, 0,      0, 0,  10, 0, 0, 0,      0, 1, 0);
    add(1, 0, 0, 0,      0, 0, 0,      0, 0,  11, 0, 0, 0,      0, 1, 0);
    @(posedge clk);
    #1;
    q.delete(); mbusy = 0; merr = 0; mwe = 0; mwa = 0; mwd = 0;
    chk("reset_we", we, 0);
    chk("reset_err", err, 0);
    foreach (tbl[i]) apply(tbl[i], 1);
    for (int i = 0; i < 2000; i++) begin
      v = tbl[0];
      v.rst = ($urandom_range(0, 59) != 0);
      v.pwe = ($urandom_range(0, 1) == 1);
      v.pa  = 5'($urandom_range(0, 7));
      v.pd  = $urandom;
      v.lv  = ($urandom_range(0, 4) < 2);
      v.la  = 5'($urandom_range(0, 7));
      v.ld  = $urandom;
      v.iv  = ($urandom_range(0, 3) == 0);
      v.ia  = 5'($urandom_range(0, 7));
      v.r1  = 5'($urandom_range(0, 7));
      v.r2  = 5'($urandom_range(0, 7));
      apply(v, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
